// File: rtl/lcd_pkg.sv
// Shared types and HD44780 constants for the LCD read-back controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_SETADDR,
    ST_POLL,
    ST_RD,
    ST_DONE
  } rd_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EHIGH,
    PH_ELOW
  } nib_phase_e;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic       RS_CMD            = 1'b0;
  localparam logic       RS_DATA           = 1'b1;
  localparam logic       RW_WR             = 1'b0;
  localparam logic       RW_RD             = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_nibble_cycle.sv
// One HD44780 nibble transfer: SETUP (E low) -> EHIGH -> ELOW, T_AS+T_EH+T_EL cycles.
// A start in the done cycle chains the next nibble with no gap.
module lcd_nibble_cycle
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS = 3,
  parameter int unsigned T_EH = 13,
  parameter int unsigned T_EL = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rd_i,
  input  logic [3:0] nibble_i,
  output logic       e_o,
  output logic       oe_o,
  output logic [3:0] dat_o,
  output logic       sample_o,
  output logic       done_o
);

  localparam int unsigned CNT_W = $clog2(max3(T_AS, T_EH, T_EL) + 1);

  nib_phase_e       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic [3:0]       dat_q, dat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b1;
      dat_q   <= 4'h0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q + CNT_W'(1);
    rd_d     = rd_q;
    dat_d    = dat_q;
    sample_o = 1'b0;
    done_o   = 1'b0;
    case (phase_q)
      PH_SETUP: if (cnt_q == CNT_W'(T_AS - 1)) begin
        phase_d = PH_EHIGH;
        cnt_d   = '0;
      end
      PH_EHIGH: if (cnt_q == CNT_W'(T_EH - 1)) begin
        sample_o = 1'b1;
        phase_d  = PH_ELOW;
        cnt_d    = '0;
      end
      PH_ELOW: if (cnt_q == CNT_W'(T_EL - 1)) begin
        done_o  = 1'b1;
        phase_d = PH_IDLE;
        cnt_d   = '0;
      end
      default: cnt_d = '0;
    endcase
    if (start_i) begin
      phase_d = PH_SETUP;
      cnt_d   = '0;
      rd_d    = rd_i;
      dat_d   = nibble_i;
    end
  end

  assign e_o   = (phase_q == PH_EHIGH);
  // Reads release the data bus for the whole nibble, writes drive it throughout.
  assign oe_o  = (phase_q != PH_IDLE) && !rd_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/lcd_readback.sv
// HD44780 4-bit read-back controller: busy-flag/AC read or one DDRAM character read.
// Optional poll timeout when LCD_RD_TIMEOUT_EN is defined (err tied low otherwise).
module lcd_readback
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS     = 3,
  parameter int unsigned T_EH     = 13,
  parameter int unsigned T_EL     = 13,
  parameter int unsigned POLL_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       mode,
  input  logic [6:0] addr,
  output logic       ready,
  output logic       valid,
  output logic [7:0] rdata,
  output logic       bf,
  output logic [6:0] ac,
  output logic       err,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_dat_out,
  input  logic [3:0] lcd_dat_in,
  output logic       lcd_dat_oe
);

  rd_state_e  state_q, state_d;
  logic       sel_q, sel_d;          // 0 = high nibble, 1 = low nibble
  logic       mode_q;
  logic [6:0] addr_q;
  logic [3:0] hi_q, lo_q;
  logic [7:0] rdata_q;
  logic       bf_q;
  logic [6:0] ac_q;

  logic       accept;
  logic       timeout_hit;
  logic [7:0] cmd_byte;
  logic       nib_start, nib_rd, nib_e, nib_oe, nib_sample, nib_done;
  logic [3:0] nib_data, nib_dat;

  assign ready    = (state_q == ST_IDLE) && !rst;
  assign accept   = req && ready;
  assign cmd_byte = LCD_CMD_SET_DDRAM | {1'b0, addr_q};

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    nib_start = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_WAIT_GNT;
      ST_WAIT_GNT: if (bus_gnt) begin
        state_d   = mode_q ? ST_SETADDR : ST_POLL;
        sel_d     = 1'b0;
        nib_start = 1'b1;
      end
      ST_SETADDR, ST_POLL, ST_RD: if (nib_done) begin
        if (!sel_q) begin
          sel_d     = 1'b1;
          nib_start = 1'b1;
        end else begin
          sel_d = 1'b0;
          if (state_q == ST_SETADDR) begin
            state_d   = ST_POLL;
            nib_start = 1'b1;
          end else if (state_q == ST_RD || !mode_q) begin
            state_d = ST_DONE;
          end else if (!hi_q[3]) begin
            state_d   = ST_RD;
            nib_start = 1'b1;
          end else if (timeout_hit) begin
            state_d = ST_DONE;
          end else begin
            nib_start = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The nibble being launched belongs to the state being entered.
  assign nib_rd   = (state_d != ST_SETADDR);
  assign nib_data = sel_d ? cmd_byte[3:0] : cmd_byte[7:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      mode_q  <= 1'b0;
      addr_q  <= 7'h00;
      hi_q    <= 4'h0;
      lo_q    <= 4'h0;
      rdata_q <= 8'h00;
      bf_q    <= 1'b0;
      ac_q    <= 7'h00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (accept) begin
        mode_q <= mode;
        addr_q <= addr;
      end
      if (nib_sample && (state_q == ST_POLL || state_q == ST_RD)) begin
        if (sel_q) lo_q <= lcd_dat_in;
        else       hi_q <= lcd_dat_in;
      end
      if (nib_done && sel_q && state_q == ST_POLL) begin
        bf_q <= hi_q[3];
        ac_q <= {hi_q[2:0], lo_q};
      end
      if (nib_done && sel_q && state_q == ST_RD) rdata_q <= {hi_q, lo_q};
    end
  end

`ifdef LCD_RD_TIMEOUT_EN
  localparam int unsigned PCNT_W = $clog2(POLL_MAX + 1);

  logic [PCNT_W-1:0] poll_cnt_q;
  logic              timeout_q;
  logic              poll_enter, poll_busy_done;

  assign poll_enter     = nib_start && (state_d == ST_POLL) && (state_q != ST_POLL);
  assign poll_busy_done = (state_q == ST_POLL) && nib_done && sel_q && mode_q && hi_q[3];
  assign timeout_hit    = (poll_cnt_q == PCNT_W'(POLL_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (poll_enter)          poll_cnt_q <= '0;
      else if (poll_busy_done) poll_cnt_q <= poll_cnt_q + PCNT_W'(1);
      if (accept)                             timeout_q <= 1'b0;
      else if (poll_busy_done && timeout_hit) timeout_q <= 1'b1;
    end
  end

  assign err = (state_q == ST_DONE) && timeout_q;
`else
  logic unused_poll_max;
  assign unused_poll_max = (POLL_MAX != 0);
  assign timeout_hit     = 1'b0;
  assign err             = 1'b0;
`endif

  lcd_nibble_cycle #(
    .T_AS (T_AS),
    .T_EH (T_EH),
    .T_EL (T_EL)
  ) u_nibble (
    .clk      (clk),
    .rst      (rst),
    .start_i  (nib_start),
    .rd_i     (nib_rd),
    .nibble_i (nib_data),
    .e_o      (nib_e),
    .oe_o     (nib_oe),
    .dat_o    (nib_dat),
    .sample_o (nib_sample),
    .done_o   (nib_done)
  );

  always_comb begin
    lcd_rs = RS_CMD;
    lcd_rw = RW_RD;
    case (state_q)
      ST_SETADDR: lcd_rw = RW_WR;
      ST_RD:      lcd_rs = RS_DATA;
      default:    ;
    endcase
  end

  assign valid       = (state_q == ST_DONE);
  assign bus_req     = (state_q == ST_WAIT_GNT) || (state_q == ST_SETADDR) ||
                       (state_q == ST_POLL) || (state_q == ST_RD);
  assign rdata       = rdata_q;
  assign bf          = bf_q;
  assign ac          = ac_q;
  assign lcd_e       = nib_e;
  assign lcd_dat_oe  = nib_oe;
  assign lcd_dat_out = nib_dat;

endmodule
